// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, MEM-stage state encoding and the EX/MEM
// field bundle that the MEM stage captures while a memory access is in flight.
package mips_pkg;

  localparam int DATA_W                 = 32;
  localparam int REG_ADDR_W             = 5;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

  typedef struct packed {
    logic                  regWrite;
    logic                  moveNotZero;
    logic                  dontMove;
    logic                  hiOrLo;
    logic                  memToReg;
    logic                  hiLoToReg;
    logic                  memWrite;
    logic                  lb;
    logic                  loadExtended;
    logic                  zero;
    logic [DATA_W-1:0]     aluResult;
    logic [DATA_W-1:0]     rHi;
    logic [DATA_W-1:0]     rLo;
    logic [REG_ADDR_W-1:0] writeAddress;
  } exMemT;

  // movn writes when Zero=0, movz when Zero=1; stores never touch the register file.
  function automatic logic effectiveWrite(exMemT f);
    return f.regWrite & (f.dontMove | (f.moveNotZero ^ f.zero)) & ~f.memWrite;
  endfunction

endpackage

// File: rtl/mem_stage_wb_load_align.sv
// Byte-lane select and sign/zero extension for load data (little-endian lanes).
module load_align
  import mips_pkg::*;
(
  input  logic [1:0]        byteSel,
  input  logic              lb,
  input  logic              loadExtended,
  input  logic [DATA_W-1:0] rData,
  output logic [DATA_W-1:0] loadData
);

  logic [7:0] lane;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    case (byteSel)
      2'd0:    lane = rData[7:0];
      2'd1:    lane = rData[15:8];
      2'd2:    lane = rData[23:16];
      default: lane = rData[31:24];
    endcase
    loadData = lb ? {{(DATA_W-8){loadExtended & lane[7]}}, lane} : rData;
  end

endmodule

// File: rtl/mem_stage_wb.sv
// MEM-stage controller and MEM/WB register. State updates on negedge Clk.
// Optional ack timeout with sticky BusError when MEM_TIMEOUT_EN is defined.
module mem_stage_wb
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  ValidIn,
  input  logic                  RegWriteIn,
  input  logic                  MoveNotZeroIn,
  input  logic                  DontMoveIn,
  input  logic                  HiOrLoIn,
  input  logic                  MemToRegIn,
  input  logic                  HiLoToRegIn,
  input  logic                  MemWriteIn,
  input  logic                  MemReadIn,
  input  logic                  LbIn,
  input  logic                  LoadExtendedIn,
  input  logic                  ZeroIn,
  input  logic [DATA_W-1:0]     ALUResultIn,
  input  logic [DATA_W-1:0]     RD2In,
  input  logic [DATA_W-1:0]     RHiIn,
  input  logic [DATA_W-1:0]     RLoIn,
  input  logic [REG_ADDR_W-1:0] WriteAddressIn,
  output logic                  DMemReq,
  output logic                  DMemWe,
  output logic [ADDR_W-1:0]     DMemAddr,
  output logic [DATA_W-1:0]     DMemWData,
  input  logic                  DMemAck,
  input  logic [DATA_W-1:0]     DMemRData,
  output logic                  Stall,
  output logic                  ValidOut,
  output logic                  RegWriteOut,
  output logic [REG_ADDR_W-1:0] WriteAddressOut,
  output logic [DATA_W-1:0]     WriteDataOut,
  output logic                  Misaligned
`ifdef MEM_TIMEOUT_EN
  , output logic                BusError
`endif
);

  logic              state, nextState;
  logic              memop;
  logic              timeoutNow;
  logic              accessDone;
  exMemT             live, held, cur;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] wbData;
  logic              wbWrite;
  logic              wbMisaligned;

  assign memop = ValidIn & (MemReadIn | MemWriteIn);

  assign live = '{
    regWrite:     RegWriteIn,
    moveNotZero:  MoveNotZeroIn,
    dontMove:     DontMoveIn,
    hiOrLo:       HiOrLoIn,
    memToReg:     MemToRegIn,
    hiLoToReg:    HiLoToRegIn,
    memWrite:     MemWriteIn,
    lb:           LbIn,
    loadExtended: LoadExtendedIn,
    zero:         ZeroIn,
    aluResult:    ALUResultIn,
    rHi:          RHiIn,
    rLo:          RLoIn,
    writeAddress: WriteAddressIn
  };

  // While an access is outstanding the record is built from the captured fields.
  assign cur = (state == ST_ACCESS) ? held : live;

  load_align uLoadAlign (
    .byteSel      (cur.aluResult[1:0]),
    .lb           (cur.lb),
    .loadExtended (cur.loadExtended),
    .rData        (DMemRData),
    .loadData     (loadData)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] waitCnt;

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  waitCnt <= '0;
    else if (state == ST_ACCESS) waitCnt <= waitCnt + 1'b1;
    else                         waitCnt <= '0;
  end

  assign timeoutNow = (state == ST_ACCESS) & ~DMemAck & (waitCnt == CNT_LAST);

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n)          BusError <= 1'b0;
    else if (timeoutNow) BusError <= 1'b1;
  end
`else
  assign timeoutNow = 1'b0;
`endif

  assign accessDone = DMemAck | timeoutNow;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (memop) nextState = ST_ACCESS;
      default:   if (accessDone) nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state)
      ST_IDLE: Stall = memop;
      default: Stall = ~accessDone;
    endcase
    Stall = Stall & Rst_n;

    if (cur.memToReg)       wbData = loadData;
    else if (cur.hiLoToReg) wbData = cur.hiOrLo ? cur.rHi : cur.rLo;
    else                    wbData = cur.aluResult;

    wbWrite      = effectiveWrite(cur);
    wbMisaligned = ~cur.lb & (cur.aluResult[1:0] != 2'b00);
  end

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      held            <= '0;
      DMemReq         <= 1'b0;
      DMemWe          <= 1'b0;
      DMemAddr        <= '0;
      DMemWData       <= '0;
      ValidOut        <= 1'b0;
      RegWriteOut     <= 1'b0;
      WriteAddressOut <= '0;
      WriteDataOut    <= '0;
      Misaligned      <= 1'b0;
    end else begin
      ValidOut    <= 1'b0;
      RegWriteOut <= 1'b0;
      Misaligned  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (memop) begin
            held      <= live;
            DMemReq   <= 1'b1;
            DMemWe    <= MemWriteIn;
            DMemAddr  <= {ALUResultIn[ADDR_W-1:2], 2'b00};
            DMemWData <= RD2In;
          end else begin
            ValidOut        <= ValidIn;
            RegWriteOut     <= ValidIn & wbWrite;
            WriteAddressOut <= cur.writeAddress;
            WriteDataOut    <= wbData;
          end
        end
        default: begin
          // A timed-out access still retires its slot, but writes nothing.
          if (accessDone) begin
            DMemReq         <= 1'b0;
            DMemWe          <= 1'b0;
            ValidOut        <= 1'b1;
            RegWriteOut     <= wbWrite & ~timeoutNow;
            WriteAddressOut <= cur.writeAddress;
            WriteDataOut    <= timeoutNow ? '0 : wbData;
            Misaligned      <= wbMisaligned;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed self-checking bench for mem_stage_wb: a spec-level record model plus
// a per-cycle compare process, pinned by hand-computed literal expectations.
`timescale 1ns/1ps
module tb_mem_stage_wb;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ValidIn, RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn;
  logic        HiLoToRegIn, MemWriteIn, MemReadIn, LbIn, LoadExtendedIn, ZeroIn;
  logic [31:0] ALUResultIn, RD2In, RHiIn, RLoIn;
  logic [4:0]  WriteAddressIn;
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr, DMemWData;
  logic        DMemAck;
  logic [31:0] DMemRData;
  logic        Stall, ValidOut, RegWriteOut, Misaligned;
  logic [4:0]  WriteAddressOut;
  logic [31:0] WriteDataOut;
`ifdef MEM_TIMEOUT_EN
  logic        BusError;
`endif

  mem_stage_wb dut (
    .Clk(Clk), .Rst_n(Rst_n), .ValidIn(ValidIn), .RegWriteIn(RegWriteIn),
    .MoveNotZeroIn(MoveNotZeroIn), .DontMoveIn(DontMoveIn), .HiOrLoIn(HiOrLoIn),
    .MemToRegIn(MemToRegIn), .HiLoToRegIn(HiLoToRegIn), .MemWriteIn(MemWriteIn),
    .MemReadIn(MemReadIn), .LbIn(LbIn), .LoadExtendedIn(LoadExtendedIn), .ZeroIn(ZeroIn),
    .ALUResultIn(ALUResultIn), .RD2In(RD2In), .RHiIn(RHiIn), .RLoIn(RLoIn),
    .WriteAddressIn(WriteAddressIn), .DMemReq(DMemReq), .DMemWe(DMemWe),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemAck(DMemAck), .DMemRData(DMemRData),
    .Stall(Stall), .ValidOut(ValidOut), .RegWriteOut(RegWriteOut),
    .WriteAddressOut(WriteAddressOut), .WriteDataOut(WriteDataOut), .Misaligned(Misaligned)
`ifdef MEM_TIMEOUT_EN
    , .BusError(BusError)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        regWrite, moveNotZero, dontMove, hiOrLo, memToReg, hiLoToReg;
    logic        memWrite, memRead, lb, loadExtended, zero;
    logic [31:0] alu, rd2, rHi, rLo;
    logic [4:0]  wa;
  } instrT;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] data;
    logic        mis;
  } recT;

  int          nChecks = 0;
  int          nFails  = 0;
  recT         expQ[$];
  logic [31:0] expAddr, expWData;
  logic        expWe;
  int          ackWait = 0;
  logic [31:0] memWord = 32'h0;
  logic [31:0] seenAddr, seenWData;
  logic        seenWe;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("FAIL %s: actual 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic instrT blank();
    instrT v;
    v.regWrite = 0; v.moveNotZero = 0; v.dontMove = 0; v.hiOrLo = 0; v.memToReg = 0;
    v.hiLoToReg = 0; v.memWrite = 0; v.memRead = 0; v.lb = 0; v.loadExtended = 0; v.zero = 0;
    v.alu = 0; v.rd2 = 0; v.rHi = 0; v.rLo = 0; v.wa = 0;
    return v;
  endfunction

  function automatic instrT aluOp(logic [31:0] alu, logic [4:0] wa);
    instrT v;
    v = blank(); v.regWrite = 1; v.dontMove = 1; v.alu = alu; v.wa = wa;
    return v;
  endfunction

  function automatic instrT loadOp(logic [31:0] addr, logic [4:0] wa, logic lb, logic ext);
    instrT v;
    v = aluOp(addr, wa); v.memRead = 1; v.memToReg = 1; v.lb = lb; v.loadExtended = ext;
    v.rd2 = 32'h5A5A_0001;
    return v;
  endfunction

  function automatic instrT storeOp(logic [31:0] addr, logic [31:0] data);
    instrT v;
    v = aluOp(addr, 5'd31); v.memWrite = 1; v.rd2 = data;
    return v;
  endfunction

  function automatic instrT moveOp(logic movn, logic zero, logic [31:0] val, logic [4:0] wa);
    instrT v;
    v = aluOp(val, wa); v.dontMove = 0; v.moveNotZero = movn; v.zero = zero;
    return v;
  endfunction

  // What the register file must see for one instruction, from the architectural rules.
  function automatic recT predict(instrT v, logic [31:0] word, bit timedOut);
    recT         r;
    logic [7:0]  b;
    logic [31:0] load;
    bit          moveOk;
    b = word[8*int'(v.alu[1:0]) +: 8];
    if (!v.lb)                        load = word;
    else if (v.loadExtended && b[7])  load = {24'hFF_FFFF, b};
    else                              load = {24'h0, b};
    r.data = v.memToReg ? load : (v.hiLoToReg ? (v.hiOrLo ? v.rHi : v.rLo) : v.alu);
    moveOk = v.dontMove || (v.moveNotZero ? (v.zero == 1'b0) : (v.zero == 1'b1));
    r.we   = v.regWrite && moveOk && !v.memWrite;
    r.mis  = (v.memRead || v.memWrite) && !v.lb && (v.alu[1:0] != 2'b00);
    r.wa   = v.wa;
    if (timedOut) begin r.data = 32'h0; r.we = 1'b0; end
    return r;
  endfunction

  task automatic drive(input instrT v);
    RegWriteIn = v.regWrite; MoveNotZeroIn = v.moveNotZero; DontMoveIn = v.dontMove;
    HiOrLoIn = v.hiOrLo; MemToRegIn = v.memToReg; HiLoToRegIn = v.hiLoToReg;
    MemWriteIn = v.memWrite; MemReadIn = v.memRead; LbIn = v.lb;
    LoadExtendedIn = v.loadExtended; ZeroIn = v.zero;
    ALUResultIn = v.alu; RD2In = v.rd2; RHiIn = v.rHi; RLoIn = v.rLo; WriteAddressIn = v.wa;
  endtask

  task automatic setBus(input instrT v);
    expAddr = {v.alu[31:2], 2'b00}; expWe = v.memWrite; expWData = v.rd2;
  endtask

  // Called at a slot start (just after a negedge); returns at the next slot start.
  task automatic issue(input instrT v, input logic [31:0] word, input int waitCycles, output int stalls);
    ackWait = waitCycles;
    memWord = word;
    setBus(v);
    expQ.push_back(predict(v, word, waitCycles < 0));
    drive(v);
    ValidIn = 1'b1;
    stalls = 0;
    @(posedge Clk);
    while (Stall && stalls < 64) begin
      stalls++;
      @(posedge Clk);
    end
    check("stallRelease", Stall, 0);
    @(negedge Clk); #1;
    ValidIn = 1'b0;
  endtask

  // Memory: acks after ackWait cycles of visible request; negative means never.
  initial begin : memResponder
    int reqAge;
    reqAge = 0; DMemAck = 1'b0; DMemRData = 32'h0;
    forever begin
      @(negedge Clk); #1;
      if (Rst_n && DMemReq) begin
        if (ackWait >= 0 && reqAge == ackWait) begin
          DMemAck = 1'b1; DMemRData = memWord;
          seenAddr = DMemAddr; seenWe = DMemWe; seenWData = DMemWData;
        end else begin
          DMemAck = 1'b0; DMemRData = ~memWord;
        end
        reqAge++;
      end else begin
        DMemAck = 1'b0; DMemRData = ~memWord; reqAge = 0;
      end
    end
  end

  initial begin : compareProc
    recT r;
    forever begin
      @(posedge Clk);
      if (Rst_n) begin
        if (ValidOut) begin
          if (expQ.size() == 0) begin
            check("unexpectedRecord", ValidOut, 0);
          end else begin
            r = expQ.pop_front();
            check("modelRegWrite", RegWriteOut, r.we);
            check("modelWriteAddr", WriteAddressOut, r.wa);
            check("modelWriteData", WriteDataOut, r.data);
            check("modelMisaligned", Misaligned, r.mis);
          end
        end else begin
          check("bubbleRegWrite", RegWriteOut, 0);
          check("bubbleMisaligned", Misaligned, 0);
        end
        if (DMemReq) begin
          check("busAddr", DMemAddr, expAddr);
          check("busWe", DMemWe, expWe);
          check("busWData", DMemWData, expWData);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : mainSeq
    int    st;
    instrT v;
    drive(blank()); ValidIn = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rstDMemReq", DMemReq, 0);
    check("rstDMemAddr", DMemAddr, 0);
    check("rstValidOut", ValidOut, 0);
    check("rstWriteData", WriteDataOut, 0);
    check("rstStall", Stall, 0);
`ifdef MEM_TIMEOUT_EN
    check("rstBusError", BusError, 0);
`endif
    Rst_n = 1'b1;
    @(negedge Clk); #1;

    // Plain ALU op: one-edge latency, no stall.
    issue(aluOp(32'h1234, 5'd5), 32'h0, 0, st);
    check("aluStalls", st, 0);
    check("aluValid", ValidOut, 1);
    check("aluRegWrite", RegWriteOut, 1);
    check("aluAddr", WriteAddressOut, 5);
    check("aluData", WriteDataOut, 32'h1234);
    @(negedge Clk); #1;
    check("validPulse", ValidOut, 0);

    // Byte loads from lane 3, back to back: sign- then zero-extended.
    issue(loadOp(32'h103, 5'd7, 1, 1), 32'h80FF_FF7F, 3, st);
    check("lbSxStalls", st, 4);
    check("lbSxData", WriteDataOut, 32'hFFFF_FF80);
    check("lbSxMisaligned", Misaligned, 0);
    issue(loadOp(32'h103, 5'd8, 1, 0), 32'h80FF_FF7F, 3, st);
    check("lbZxStalls", st, 4);
    check("lbZxData", WriteDataOut, 32'h0000_0080);
    @(posedge Clk);
    check("invalidNoReq", DMemReq, 0);
    check("invalidNoStall", Stall, 0);
    @(negedge Clk); #1;

    // Other byte lanes through the model only.
    issue(loadOp(32'h401, 5'd9, 1, 1), 32'h1122_8344, 1, st);
    issue(loadOp(32'h402, 5'd9, 1, 1), 32'h11A2_3344, 2, st);

    // Store: bus held until ack, never writes the register file.
    issue(storeOp(32'h40, 32'hDEAD_BEEF), 32'h0, 2, st);
    check("swStalls", st, 3);
    check("swAddr", seenAddr, 32'h40);
    check("swWe", seenWe, 1);
    check("swWData", seenWData, 32'hDEAD_BEEF);
    check("swRegWrite", RegWriteOut, 0);

    // Conditional moves and Hi/Lo selection.
    issue(moveOp(0, 0, 32'h77, 5'd12), 32'h0, 0, st);
    check("movzZ0", RegWriteOut, 0);
    issue(moveOp(0, 1, 32'h77, 5'd12), 32'h0, 0, st);
    check("movzZ1", RegWriteOut, 1);
    issue(moveOp(1, 0, 32'h77, 5'd13), 32'h0, 0, st);
    check("movnZ0", RegWriteOut, 1);
    issue(moveOp(1, 1, 32'h77, 5'd13), 32'h0, 0, st);
    v = aluOp(32'h55, 5'd9); v.hiLoToReg = 1; v.hiOrLo = 1; v.rHi = 32'hAAAA_0000; v.rLo = 32'h0000_BBBB;
    issue(v, 32'h0, 0, st);
    check("mfhiData", WriteDataOut, 32'hAAAA_0000);
    v.hiOrLo = 0;
    issue(v, 32'h0, 0, st);
    check("mfloData", WriteDataOut, 32'h0000_BBBB);

    // Ack in the same cycle the request first appears.
    issue(loadOp(32'h200, 5'd3, 0, 0), 32'hCAFE_F00D, 0, st);
    check("lwFastStalls", st, 1);
    check("lwFastData", WriteDataOut, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of an access.
    v = loadOp(32'h80, 5'd4, 0, 0);
    ackWait = -1; setBus(v); drive(v); ValidIn = 1'b1;
    @(negedge Clk); #1;
    @(posedge Clk);
    check("midAccessReq", DMemReq, 1);
    #2 Rst_n = 1'b0;
    #1;
    check("rstMidReq", DMemReq, 0);
    check("rstMidWe", DMemWe, 0);
    check("rstMidAddr", DMemAddr, 0);
    check("rstMidWData", DMemWData, 0);
    check("rstMidStall", Stall, 0);
    check("rstMidValid", ValidOut, 0);
    ValidIn = 1'b0;
    @(negedge Clk); #2 Rst_n = 1'b1;
    @(negedge Clk); #1;

    // Misaligned word load completes at the aligned address.
    issue(loadOp(32'h42, 5'd6, 0, 0), 32'h1122_3344, 1, st);
    check("lwMisFlag", Misaligned, 1);
    check("lwMisAddr", seenAddr, 32'h40);
    check("lwMisData", WriteDataOut, 32'h1122_3344);
    @(negedge Clk); #1;
    check("misPulse", Misaligned, 0);

`ifdef MEM_TIMEOUT_EN
    issue(loadOp(32'h300, 5'd10, 0, 0), 32'h1234_5678, -1, st);
    check("toStalls", st, 16);
    check("toReq", DMemReq, 0);
    check("toBusError", BusError, 1);
    check("toRegWrite", RegWriteOut, 0);
    check("toData", WriteDataOut, 0);
    issue(aluOp(32'h9, 5'd2), 32'h0, 0, st);
    check("busErrorSticky", BusError, 1);
`endif

    @(negedge Clk); #1;
    check("queueDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_stage_wb.md
Name: mem_stage_wb

Overview:
- MEM-stage controller plus MEM/WB pipeline register, directly downstream of the EX/MEM register.
- Drives a handshaked external data-memory port and stalls the pipeline while an access is outstanding.
- Extracts and extends byte loads, resolves movn/movz write enables, and selects the final write-back value from memory, ALU, Hi or Lo.
- Delivers one registered write-back record per instruction to the register file.

Parameters:
- ADDR_W, 32, data-memory address width.
- TIMEOUT_CYCLES, 16, ack wait limit; used only with MEM_TIMEOUT_EN.

Ports:
- Clk  in  1  clock; all state updates on negedge Clk, matching the stage registers.
- Rst_n  in  1  asynchronous active-low reset.
- ValidIn  in  1  EX/MEM slot holds a real instruction.
- RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn, HiLoToRegIn, MemWriteIn, MemReadIn, LbIn, LoadExtendedIn, ZeroIn  in  1 each  control from EX/MEM.
- ALUResultIn, RD2In, RHiIn, RLoIn  in  32 each  datapath from EX/MEM.
- WriteAddressIn  in  5  destination register.
- DMemReq  out  1  memory request, registered.
- DMemWe  out  1  write strobe, registered.
- DMemAddr  out  ADDR_W  word-aligned address.
- DMemWData  out  32  store data.
- DMemAck  in  1  access complete; sampled only while DMemReq=1.
- DMemRData  in  32  read data, valid with DMemAck.
- Stall  out  1  combinational; hazard unit holds PC, IF/ID, ID/EX and EX/MEM while it is 1.
- ValidOut  out  1  write-back record valid (1-cycle pulse).
- RegWriteOut  out  1  final register-file write enable.
- WriteAddressOut  out  5  destination register.
- WriteDataOut  out  32  selected write-back value.
- Misaligned  out  1  1-cycle pulse for a word access with ALUResultIn[1:0]!=0.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset is asynchronous, so DMemReq drops immediately even mid-access; the pending access is abandoned.
- memop = ValidIn & (MemReadIn | MemWriteIn).
- States: IDLE, ACCESS.
- IDLE, no memop: on the next edge, register the write-back record with ValidOut=ValidIn. Latency is 1 edge.
- IDLE, memop: Stall=1. Latch the control and data inputs. On the next edge, go to ACCESS and drive DMemReq=1, DMemWe=MemWriteIn, DMemAddr={ALUResultIn[ADDR_W-1:2],2'b00}, DMemWData=RD2In.
- ACCESS: hold DMemReq and all bus outputs stable. Stall = ~DMemAck.
  - On an edge with DMemAck=1: DMemReq=0, go to IDLE, and register the write-back record from the latched fields plus DMemRData.
  - Ack in the same cycle the request first appears is legal.
- Between records, ValidOut=0 and RegWriteOut=0 (bubble).
- Effective write enable: RegWriteOut = valid & RegWrite & (DontMove | (MoveNotZero ^ Zero)). movn (MoveNotZero=1) writes when Zero=0; movz writes when Zero=1.
- Load data:
  - Lb: byte lane = addr[1:0], little-endian (lane 0 = bits 7:0). LoadExtended=1 sign-extends, 0 zero-extends.
  - Otherwise the full word.
- WriteDataOut = MemToReg ? loaddata : HiLoToReg ? (HiOrLo ? RHi : RLo) : ALUResult.
- Stores never write the register file: RegWriteOut is forced 0 when MemWrite=1.
- Misaligned:
  - Pulses with the write-back record when a non-Lb access has addr[1:0]!=0.
  - The access still completes at the aligned address. There is no exception.
- Back-to-back memops: each costs a minimum of 2 edges. Stall stays 1 through the IDLE cycle of each memop.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined: a counter runs in ACCESS. If TIMEOUT_CYCLES edges pass with no ack:
  - DMemReq drops and state returns to IDLE.
  - The record is written back with WriteDataOut=0 and RegWriteOut=0.
  - Sticky output BusError (1 bit) is set; it clears only on reset.
- Undefined: the block waits for an ack indefinitely, and there is no BusError port.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding localparams: ST_IDLE=1'b0, ST_ACCESS=1'b1;
  - width constants DATA_W=32, REG_ADDR_W=5;
  - TIMEOUT_CYCLES default.
- One sub-module, load_align: combinational byte-lane select and extend (addr[1:0], Lb, LoadExtended, rdata -> loaddata).

Test Plan:
- ALU op, RegWrite=1, ALUResult=0x1234, WriteAddress=5 -> after 1 edge: ValidOut=1, RegWriteOut=1, WriteDataOut=0x1234, Stall never asserted.
- Lb at addr 0x103, LoadExtended=1, memory returns 0x80FF_FF7F after 3 wait cycles -> Stall=1 for 4 cycles, then WriteDataOut=0xFFFF_FF80. Repeat with LoadExtended=0 -> 0x0000_0080.
- sw of RD2=0xDEADBEEF to addr 0x40 -> DMemAddr=0x40, DMemWe=1, DMemWData=0xDEADBEEF held until ack; RegWriteOut=0.
- movz with Zero=0 -> RegWriteOut=0. Same instruction with Zero=1 -> RegWriteOut=1. movn with Zero=0 -> 1. HiLoToReg=1, HiOrLo=1, RHi=0xAAAA0000 -> WriteDataOut=0xAAAA0000.
- Assert Rst_n=0 mid-ACCESS -> DMemReq falls immediately and all outputs are 0. Release, then issue a lw at 0x42 -> Misaligned=1, DMemAddr=0x40.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never arrives -> after 16 edges DMemReq=0, BusError=1 (sticky), RegWriteOut=0.
